// File: rtl/req_ack_responder_if.sv
// Req/ack handshake bundle: request with payload from the initiator, ack with echoed payload back.
interface req_ack_responder_if #(
    parameter int DATA_W = 8
);
    logic              req;
    logic [DATA_W-1:0] req_data;
    logic              ack;
    logic [DATA_W-1:0] ack_data;

    modport master (output req, output req_data, input ack, input ack_data);
    modport slave  (input req, input req_data, output ack, output ack_data);
endinterface

// File: rtl/req_ack_responder.sv
// Responder end of the req/ack handshake: every accepted request is acked ACK_LAT cycles later
// with its payload echoed, plus saturating accept/ack/drop statistics.
//
// state  | meaning
// IDLE   | nothing in flight, waiting for a request
// ACTIVE | requests in flight while enable is high
// DRAIN  | enable dropped; delivering in-flight acks, no new accepts
module req_ack_responder #(
    parameter int DATA_W  = 8,
    parameter int ACK_LAT = 1,
    parameter int CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    req_ack_responder_if.slave   hs,
    input  logic                 enable,
    output logic                 busy,
    output logic [1:0]           state,
    output logic [CNT_W-1:0]     req_cnt,
    output logic [CNT_W-1:0]     ack_cnt,
    output logic [CNT_W-1:0]     drop_cnt
);

    if (ACK_LAT < 1 || ACK_LAT > 15) begin : g_lat_check
        $error("req_ack_responder: ACK_LAT=%0d outside legal range 1..15", ACK_LAT);
    end

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_DRAIN  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [ACK_LAT-1:0]  vld_q, vld_d;
    logic [DATA_W-1:0]   dat_q [ACK_LAT];
    logic [DATA_W-1:0]   dat_d [ACK_LAT];
    logic [CNT_W-1:0]    req_cnt_q, req_cnt_d;
    logic [CNT_W-1:0]    ack_cnt_q, ack_cnt_d;
    logic [CNT_W-1:0]    drop_cnt_q, drop_cnt_d;
    logic                accept;
    logic                drop;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
        logic [CNT_W-1:0] one;
        one = {{(CNT_W-1){1'b0}}, 1'b1};
        return (inc && (v != {CNT_W{1'b1}})) ? v + one : v;
    endfunction

    // The last stage is the ack register itself, so a request sampled at edge N
    // is on ack during the cycle after edge N+ACK_LAT-1. Payload is zeroed when
    // not valid, which keeps ack_data at 0 whenever ack is low.
    always_comb begin
        accept   = hs.req & enable;
        drop     = hs.req & ~enable;
        vld_d    = '0;
        dat_d[0] = '0;
        vld_d[0] = accept;
        dat_d[0] = accept ? hs.req_data : '0;
        for (int k = 1; k < ACK_LAT; k++) begin
            vld_d[k] = vld_q[k-1];
            dat_d[k] = dat_q[k-1];
        end
        req_cnt_d  = sat_inc(req_cnt_q, accept);
        ack_cnt_d  = sat_inc(ack_cnt_q, vld_d[ACK_LAT-1]);
        drop_cnt_d = sat_inc(drop_cnt_q, drop);
    end

    assign busy        = |vld_q;
    assign hs.ack      = vld_q[ACK_LAT-1];
    assign hs.ack_data = dat_q[ACK_LAT-1];

    // Transitions look at busy as it stands in the cycle being closed, so an ack
    // still on the wire keeps ACTIVE/DRAIN alive for that cycle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) state_d = S_ACTIVE;
            end
            S_ACTIVE: begin
                if (!accept) begin
                    if (!busy)        state_d = S_IDLE;
                    else if (!enable) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (accept)     state_d = S_ACTIVE;
                else if (!busy) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            vld_q   <= '0;
            for (int k = 0; k < ACK_LAT; k++) dat_q[k] <= '0;
            req_cnt_q  <= '0;
            ack_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            vld_q      <= vld_d;
            dat_q      <= dat_d;
            req_cnt_q  <= req_cnt_d;
            ack_cnt_q  <= ack_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign state    = state_q;
    assign req_cnt  = req_cnt_q;
    assign ack_cnt  = ack_cnt_q;
    assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_req_ack_responder.sv
// Directed bench: three responders (latency 1, latency 3, 4-bit counters) driven by one stimulus stream.
module tb_req_ack_responder;

    localparam logic [1:0] IDLE = 2'd0, ACTIVE = 2'd1, DRAIN = 2'd2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req;
    logic [7:0] req_data;
    logic       enable;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    req_ack_responder_if #(.DATA_W(8)) if1 ();
    req_ack_responder_if #(.DATA_W(8)) if3 ();
    req_ack_responder_if #(.DATA_W(8)) if4 ();

    assign if1.req = req;  assign if1.req_data = req_data;
    assign if3.req = req;  assign if3.req_data = req_data;
    assign if4.req = req;  assign if4.req_data = req_data;

    logic        busy1, busy3, busy4;
    logic [1:0]  st1, st3, st4;
    logic [15:0] rc1, ac1, dc1, rc3, ac3, dc3;
    logic [3:0]  rc4, ac4, dc4;

    req_ack_responder #(.DATA_W(8), .ACK_LAT(1), .CNT_W(16)) u1 (
        .clk(clk), .rst_n(rst_n), .hs(if1), .enable(enable), .busy(busy1), .state(st1),
        .req_cnt(rc1), .ack_cnt(ac1), .drop_cnt(dc1));
    req_ack_responder #(.DATA_W(8), .ACK_LAT(3), .CNT_W(16)) u3 (
        .clk(clk), .rst_n(rst_n), .hs(if3), .enable(enable), .busy(busy3), .state(st3),
        .req_cnt(rc3), .ack_cnt(ac3), .drop_cnt(dc3));
    req_ack_responder #(.DATA_W(8), .ACK_LAT(1), .CNT_W(4)) u4 (
        .clk(clk), .rst_n(rst_n), .hs(if4), .enable(enable), .busy(busy4), .state(st4),
        .req_cnt(rc4), .ack_cnt(ac4), .drop_cnt(dc4));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change #1 after a rising edge; outputs are read at the same point.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        req = 1'b0; req_data = 8'h00; enable = 1'b1;
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        bit         pat [7];
        logic [7:0] exp_d;
        logic [7:0] bdat [3];
        pat  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        bdat = '{8'h11, 8'h22, 8'h33};

        rst_n = 1'b0; req = 1'b0; req_data = 8'h00; enable = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ack1", if1.ack, 1'b0);
        chk("rst_data1", if1.ack_data, 8'h00);
        chk("rst_busy3", busy3, 1'b0);
        chk("rst_state1", st1, IDLE);
        chk("rst_cnt1", {rc1, ac1}, 32'h0);
        rst_n = 1'b1;

        // Alternating requests: ack mirrors req one edge later
        for (int i = 0; i < 7; i++) begin
            req = pat[i]; req_data = 8'h10 + 8'(i); enable = 1'b1;
            step();
            exp_d = pat[i] ? (8'h10 + 8'(i)) : 8'h00;
            chk("A_ack1", if1.ack, pat[i]);
            chk("A_data1", if1.ack_data, exp_d);
        end
        idle(4);
        chk("A_reqcnt1", rc1, 16'd3);
        chk("A_ackcnt1", ac1, 16'd3);
        chk("A_ackcnt3", ac3, 16'd3);
        chk("A_state1", st1, IDLE);
        chk("A_state3", st3, IDLE);

        // Three back-to-back requests
        for (int i = 0; i < 3; i++) begin
            req = 1'b1; req_data = bdat[i]; enable = 1'b1;
            step();
            chk("B_ack1", if1.ack, 1'b1);
            chk("B_data1", if1.ack_data, bdat[i]);
            chk("B_busy1", busy1, 1'b1);
            chk("B_state1", st1, ACTIVE);
        end
        idle(1);
        chk("B_ack1_end", if1.ack, 1'b0);
        chk("B_data1_end", if1.ack_data, 8'h00);
        chk("B_busy1_end", busy1, 1'b0);
        idle(1);
        chk("B_state1_idle", st1, IDLE);
        idle(3);
        chk("B_ackcnt3", ac3, 16'd6);

        // Single request through the 3-cycle delay line
        req = 1'b1; req_data = 8'hA5; enable = 1'b1;
        step();
        chk("C_ack1", if1.ack_data, 8'hA5);
        chk("C_ack3_e0", if3.ack, 1'b0);
        chk("C_busy3_e0", busy3, 1'b1);
        idle(1);
        chk("C_ack3_e1", if3.ack, 1'b0);
        chk("C_busy3_e1", busy3, 1'b1);
        idle(1);
        chk("C_ack3_e2", if3.ack, 1'b1);
        chk("C_data3_e2", if3.ack_data, 8'hA5);
        chk("C_busy3_e2", busy3, 1'b1);
        idle(1);
        chk("C_ack3_e3", if3.ack, 1'b0);
        chk("C_data3_e3", if3.ack_data, 8'h00);
        chk("C_busy3_e3", busy3, 1'b0);
        idle(1);
        chk("C_state3", st3, IDLE);
        chk("C_cnt3", {rc3, ac3}, {16'd7, 16'd7});

        // Accept, then two requests dropped while disabled
        req = 1'b1; req_data = 8'h5C; enable = 1'b1;
        step();
        chk("D_ack1_e0", if1.ack, 1'b1);
        chk("D_state1_e0", st1, ACTIVE);
        req = 1'b1; req_data = 8'h66; enable = 1'b0;
        step();
        chk("D_ack1_e1", if1.ack, 1'b0);
        chk("D_state1_e1", st1, DRAIN);
        chk("D_state3_e1", st3, DRAIN);
        chk("D_drop1_e1", dc1, 16'd1);
        req = 1'b1; req_data = 8'h77; enable = 1'b0;
        step();
        chk("D_state1_e2", st1, IDLE);
        chk("D_ack3_e2", if3.ack, 1'b1);
        chk("D_data3_e2", if3.ack_data, 8'h5C);
        idle(1);
        chk("D_ack1_e3", if1.ack, 1'b0);
        chk("D_state3_e3", st3, DRAIN);
        idle(1);
        chk("D_state3_e4", st3, IDLE);
        chk("D_drop1", dc1, 16'd2);
        chk("D_drop3", dc3, 16'd2);
        chk("D_cnt1", {rc1, ac1}, {16'd8, 16'd8});

        // Asynchronous reset with a request in flight
        req = 1'b1; req_data = 8'h77; enable = 1'b1;
        step();
        req = 1'b0; req_data = 8'h00;
        chk("E_busy3_pre", busy3, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("E_ack1_rst", if1.ack, 1'b0);
        chk("E_busy3_rst", busy3, 1'b0);
        chk("E_cnt3_rst", {rc3, ac3}, 32'h0);
        chk("E_drop1_rst", dc1, 16'd0);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("E_ack3_post", if3.ack, 1'b0);
        end
        chk("E_cnt3_post", {rc3, ac3}, 32'h0);
        chk("E_state3_post", st3, IDLE);

        // Saturation of the 4-bit counters
        for (int i = 1; i <= 20; i++) begin
            req = 1'b1; req_data = 8'(i); enable = 1'b1;
            step();
            chk("F_reqcnt4", rc4, (i > 15) ? 32'd15 : 32'(i));
        end
        chk("F_ackcnt4", ac4, 4'd15);
        idle(4);
        chk("F_ackcnt4_end", ac4, 4'd15);
        chk("F_reqcnt1", rc1, 16'd20);
        chk("F_ackcnt1", ac1, 16'd20);
        chk("F_ackcnt3", ac3, 16'd20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
